// File: rtl/amp_pkg.sv
// Shared encodings and helpers for the amplifier protection monitor.
package amp_pkg;

  typedef enum logic [1:0] {
    ST_STARTUP  = 2'd0,
    ST_RUN      = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_LOCKOUT  = 2'd3
  } amp_state_e;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_OC   = 2'd1;
  localparam logic [1:0] FC_OV   = 2'd2;
  localparam logic [1:0] FC_UV   = 2'd3;

  localparam int ADC_MAX = 1023;

  // Saturate a signed ADC word into the 10-bit code range.
  function automatic logic [9:0] clamp10(input logic signed [31:0] x);
    logic [9:0] r;
    if (x < 0) begin
      r = '0;
    end else if (x > ADC_MAX) begin
      r = 10'(ADC_MAX);
    end else begin
      r = x[9:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/prot_tick_gen.sv
// Evaluation tick divider: one-cycle tick every SAMPLE_DIV clocks.
module prot_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 30
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned CntW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SAMPLE_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CntLast);

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/amp_protect_monitor.sv
// Clamps ADC voltage/current words, computes power and gates the power stage
// through a startup / run / cooldown / lockout protection FSM.
module amp_protect_monitor
  import amp_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV    = 30,
  parameter int unsigned OV_LIMIT      = 900,
  parameter int unsigned UV_LIMIT      = 200,
  parameter int unsigned OC_LIMIT      = 800,
  parameter int unsigned OV_COUNT      = 4,
  parameter int unsigned OC_COUNT      = 2,
  parameter int unsigned STARTUP_TICKS = 64,
  parameter int unsigned RETRY_TICKS   = 1024,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] adc_v,
  input  logic [31:0] adc_a,
  input  logic        clr_fault,
  output logic        amp_en,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [1:0]  state,
  output logic [19:0] power
);

  localparam logic [9:0]  OvLimW    = 10'(OV_LIMIT);
  localparam logic [9:0]  UvLimW    = 10'(UV_LIMIT);
  localparam logic [9:0]  OcLimW    = 10'(OC_LIMIT);
  localparam logic [7:0]  OvCntW    = 8'(OV_COUNT);
  localparam logic [7:0]  OcCntW    = 8'(OC_COUNT);
  localparam logic [7:0]  MaxRetryW = 8'(MAX_RETRY);
  localparam logic [15:0] StartupW  = 16'(STARTUP_TICKS);
  localparam logic [15:0] RetryW    = 16'(RETRY_TICKS);

  logic tick;

  prot_tick_gen #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_tick_gen (
    .clk_i (clk),
    .rst_ni(rst_n),
    .tick_o(tick)
  );

  amp_state_e  state_q, state_d;
  logic        amp_en_q, amp_en_d;
  logic        fault_q, fault_d;
  logic [1:0]  fc_q, fc_d;
  logic [19:0] power_q, power_d;
  logic [9:0]  v_c_q, v_c_d;
  logic [9:0]  a_c_q, a_c_d;
  logic [15:0] startup_q, startup_d;
  logic [7:0]  oc_run_q, oc_run_d;
  logic [7:0]  ov_run_q, ov_run_d;
  logic [7:0]  retry_q, retry_d;
  logic [15:0] cool_q, cool_d;
  logic [15:0] stable_q, stable_d;

  logic       oc, ov, uv, ok;
  logic [7:0] oc_run_nxt, ov_run_nxt;
  logic       oc_trip, ov_trip, trip;

  assign oc = (a_c_q > OcLimW);
  assign ov = (v_c_q > OvLimW);
  assign uv = (v_c_q < UvLimW);
  assign ok = !oc && !ov && !uv;

  // Saturating consecutive-tick run counters, valid only on tick cycles.
  assign oc_run_nxt = !oc ? '0 : (oc_run_q >= OcCntW) ? oc_run_q : oc_run_q + 8'd1;
  assign ov_run_nxt = !ov ? '0 : (ov_run_q >= OvCntW) ? ov_run_q : ov_run_q + 8'd1;
  assign oc_trip    = (oc_run_nxt >= OcCntW);
  assign ov_trip    = (ov_run_nxt >= OvCntW);
  assign trip       = oc_trip || ov_trip || uv;

  always_comb begin
    state_d   = state_q;
    amp_en_d  = amp_en_q;
    fault_d   = fault_q;
    fc_d      = fc_q;
    power_d   = power_q;
    startup_d = startup_q;
    oc_run_d  = oc_run_q;
    ov_run_d  = ov_run_q;
    retry_d   = retry_q;
    cool_d    = cool_q;
    stable_d  = stable_q;
    v_c_d     = clamp10(adc_v);
    a_c_d     = clamp10(adc_a);

    if (tick) begin
      power_d  = 20'(v_c_q) * 20'(a_c_q);
      oc_run_d = oc_run_nxt;
      ov_run_d = ov_run_nxt;

      unique case (state_q)
        ST_STARTUP: begin
          if (ok) begin
            startup_d = startup_q + 16'd1;
            if (startup_d == StartupW) begin
              state_d   = ST_RUN;
              amp_en_d  = 1'b1;
              startup_d = '0;
              stable_d  = '0;
            end
          end else begin
            startup_d = '0;
          end
        end
        ST_RUN: begin
          if (trip) begin
            amp_en_d = 1'b0;
            fault_d  = 1'b1;
            fc_d     = oc_trip ? FC_OC : (ov_trip ? FC_OV : FC_UV);
            retry_d  = retry_q + 8'd1;
            state_d  = (retry_d <= MaxRetryW) ? ST_COOLDOWN : ST_LOCKOUT;
            cool_d   = '0;
            stable_d = '0;
          end else begin
            // A long clean run re-arms the auto-retry budget.
            stable_d = stable_q + 16'd1;
            if (stable_q == 16'hFFFF) begin
              retry_d = '0;
            end
          end
        end
        ST_COOLDOWN: begin
          cool_d = cool_q + 16'd1;
          if (cool_d == RetryW) begin
            state_d   = ST_STARTUP;
            fault_d   = 1'b0;
            fc_d      = FC_NONE;
            cool_d    = '0;
            startup_d = '0;
          end
        end
        ST_LOCKOUT: begin
        end
        default: begin
          state_d = ST_STARTUP;
        end
      endcase
    end

    // clr_fault acts on any cycle but only from the faulted states.
    if (clr_fault && (state_q == ST_COOLDOWN || state_q == ST_LOCKOUT)) begin
      state_d   = ST_STARTUP;
      amp_en_d  = 1'b0;
      fault_d   = 1'b0;
      fc_d      = FC_NONE;
      retry_d   = '0;
      startup_d = '0;
      oc_run_d  = '0;
      ov_run_d  = '0;
      cool_d    = '0;
      stable_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_STARTUP;
      amp_en_q  <= 1'b0;
      fault_q   <= 1'b0;
      fc_q      <= FC_NONE;
      power_q   <= '0;
      v_c_q     <= '0;
      a_c_q     <= '0;
      startup_q <= '0;
      oc_run_q  <= '0;
      ov_run_q  <= '0;
      retry_q   <= '0;
      cool_q    <= '0;
      stable_q  <= '0;
    end else begin
      state_q   <= state_d;
      amp_en_q  <= amp_en_d;
      fault_q   <= fault_d;
      fc_q      <= fc_d;
      power_q   <= power_d;
      v_c_q     <= v_c_d;
      a_c_q     <= a_c_d;
      startup_q <= startup_d;
      oc_run_q  <= oc_run_d;
      ov_run_q  <= ov_run_d;
      retry_q   <= retry_d;
      cool_q    <= cool_d;
      stable_q  <= stable_d;
    end
  end

  assign amp_en     = amp_en_q;
  assign fault      = fault_q;
  assign fault_code = fc_q;
  assign state      = state_q;
  assign power      = power_q;

endmodule

// File: tb/tb_amp_protect_monitor.sv
// Bench for amp_protect_monitor: directed vector table, corner sequences and a
// randomized run checked against a tick-level behavioural model.
module tb_amp_protect_monitor;

  localparam int SD = 4;
  localparam int OVL = 900;
  localparam int UVL = 200;
  localparam int OCL = 800;
  localparam int OVN = 4;
  localparam int OCN = 2;
  localparam int STN = 4;
  localparam int RTN = 8;
  localparam int MXR = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] adc_v = '0;
  logic [31:0] adc_a = '0;
  logic        clr_fault = 1'b0;
  logic        amp_en, fault;
  logic [1:0]  fault_code, state;
  logic [19:0] power;

  int n_checks = 0;
  int n_fail = 0;

  amp_protect_monitor #(
    .SAMPLE_DIV(SD), .OV_LIMIT(OVL), .UV_LIMIT(UVL), .OC_LIMIT(OCL),
    .OV_COUNT(OVN), .OC_COUNT(OCN), .STARTUP_TICKS(STN), .RETRY_TICKS(RTN),
    .MAX_RETRY(MXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc_v(adc_v), .adc_a(adc_a), .clr_fault(clr_fault),
    .amp_en(amp_en), .fault(fault), .fault_code(fault_code), .state(state), .power(power)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural model: plain integers, state 0..3, fault/amp derived from state.
  int m_vc, m_ac, m_tick, m_state, m_fc, m_power;
  int m_start, m_ocr, m_ovr, m_retry, m_cool, m_stable;
  bit m_was_tick;

  function automatic int clampv(input logic [31:0] w);
    int s;
    s = int'(signed'(w));
    return (s < 0) ? 0 : ((s > 1023) ? 1023 : s);
  endfunction

  task automatic model_reset();
    m_vc = 0; m_ac = 0; m_tick = 0; m_state = 0; m_fc = 0; m_power = 0;
    m_start = 0; m_ocr = 0; m_ovr = 0; m_retry = 0; m_cool = 0; m_stable = 0;
    m_was_tick = 0;
  endtask

  task automatic model_step();
    int st0, code;
    bit oc, ov, uv;
    st0 = m_state;
    m_was_tick = (m_tick == SD - 1);
    if (m_was_tick) begin
      m_power = m_vc * m_ac;
      oc = m_ac > OCL;
      ov = m_vc > OVL;
      uv = m_vc < UVL;
      m_ocr = oc ? ((m_ocr + 1 > OCN) ? OCN : m_ocr + 1) : 0;
      m_ovr = ov ? ((m_ovr + 1 > OVN) ? OVN : m_ovr + 1) : 0;
      if (m_state == 0) begin
        m_start = (!oc && !ov && !uv) ? m_start + 1 : 0;
        if (m_start == STN) begin m_state = 1; m_start = 0; m_stable = 0; end
      end else if (m_state == 1) begin
        code = (m_ocr == OCN) ? 1 : (m_ovr == OVN) ? 2 : uv ? 3 : 0;
        if (code != 0) begin
          m_fc = code;
          m_retry = m_retry + 1;
          m_state = (m_retry <= MXR) ? 2 : 3;
          m_cool = 0;
        end else begin
          m_stable = (m_stable + 1) % 65536;
          if (m_stable == 0) m_retry = 0;
        end
      end else if (m_state == 2) begin
        m_cool = m_cool + 1;
        if (m_cool == RTN) begin m_state = 0; m_fc = 0; m_cool = 0; m_start = 0; end
      end
    end
    if (clr_fault && st0 >= 2) begin
      m_state = 0; m_fc = 0; m_retry = 0;
      m_start = 0; m_ocr = 0; m_ovr = 0; m_cool = 0; m_stable = 0;
    end
    m_vc = clampv(adc_v);
    m_ac = clampv(adc_a);
    m_tick = (m_tick + 1) % SD;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int amp, input int flt,
                           input int fc, input int pwr);
    check({tag, ".state"}, 32'(state), st);
    check({tag, ".amp_en"}, 32'(amp_en), amp);
    check({tag, ".fault"}, 32'(fault), flt);
    check({tag, ".fault_code"}, 32'(fault_code), fc);
    check({tag, ".power"}, 32'(power), pwr);
  endtask

  task automatic wait_ticks(input int n);
    int k, guard;
    k = 0;
    guard = 0;
    while (k < n && guard < n * SD + 2 * SD) begin
      cycle();
      if (m_was_tick) k++;
      guard++;
    end
    n_checks++;
    if (k < n) begin
      n_fail++;
      $display("FAIL wait_ticks: got %0d ticks expected %0d", k, n);
    end
  endtask

  typedef struct {
    logic [31:0] v;
    logic [31:0] a;
    int ticks;
    int st;
    int amp;
    int flt;
    int fc;
    int pwr;
  } vec_t;

  vec_t vecs[14];
  int   hold;

  initial begin
    model_reset();
    // Clamp, startup qualification, OC trip/cooldown, OC-over-OV priority, lockout.
    vecs[0]  = '{32'hFFFF_FFF0, 32'd0,   2,  0, 0, 0, 0, 0};
    vecs[1]  = '{32'd5000,      32'd3,   1,  0, 0, 0, 0, 3069};
    vecs[2]  = '{32'd500,       32'd100, 3,  0, 0, 0, 0, 50000};
    vecs[3]  = '{32'd500,       32'd100, 1,  1, 1, 0, 0, 50000};
    vecs[4]  = '{32'd500,       32'd801, 1,  1, 1, 0, 0, 400500};
    vecs[5]  = '{32'd500,       32'd100, 1,  1, 1, 0, 0, 50000};
    vecs[6]  = '{32'd500,       32'd801, 1,  1, 1, 0, 0, 400500};
    vecs[7]  = '{32'd500,       32'd801, 1,  2, 0, 1, 1, 400500};
    vecs[8]  = '{32'd500,       32'd100, 7,  2, 0, 1, 1, 50000};
    vecs[9]  = '{32'd500,       32'd100, 1,  0, 0, 0, 0, 50000};
    vecs[10] = '{32'd500,       32'd100, 4,  1, 1, 0, 0, 50000};
    vecs[11] = '{32'd950,       32'd900, 1,  1, 1, 0, 0, 855000};
    vecs[12] = '{32'd950,       32'd900, 1,  3, 0, 1, 1, 855000};
    vecs[13] = '{32'd950,       32'd900, 20, 3, 0, 1, 1, 855000};

    #1;
    check_all("reset", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ticks(1);
    check_all("first_tick", 0, 0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      adc_v = vecs[i].v;
      adc_a = vecs[i].a;
      wait_ticks(vecs[i].ticks);
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].amp, vecs[i].flt, vecs[i].fc,
                vecs[i].pwr);
    end

    // clr_fault in LOCKOUT acts on the next edge, then startup requalifies.
    adc_v = 500; adc_a = 100; clr_fault = 1'b1;
    cycle();
    clr_fault = 1'b0;
    check_all("clr_lockout", 0, 0, 0, 0, 855000);
    wait_ticks(4);
    check_all("requalify", 1, 1, 0, 0, 50000);

    // clr_fault in RUN is ignored.
    clr_fault = 1'b1;
    cycle();
    clr_fault = 1'b0;
    check_all("clr_in_run", 1, 1, 0, 0, 50000);

    // clr_fault on the same tick as a UV trip: the trip wins.
    wait_ticks(1);
    adc_v = 100;
    hold = 0;
    while (m_tick != SD - 1 && hold < 2 * SD) begin cycle(); hold++; end
    clr_fault = 1'b1;
    cycle();
    clr_fault = 1'b0;
    check_all("trip_vs_clr", 2, 0, 1, 3, 10000);

    // clr_fault in COOLDOWN.
    clr_fault = 1'b1;
    cycle();
    clr_fault = 1'b0;
    check_all("clr_cooldown", 0, 0, 0, 0, 10000);
    adc_v = 500;
    wait_ticks(4);
    check_all("run_again", 1, 1, 0, 0, 50000);

    // Asynchronous reset mid-RUN, away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0);
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;

    // Randomized run against the model.
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 9))
          0: adc_v = $urandom;
          1: adc_v = $urandom_range(0, 199);
          2: adc_v = $urandom_range(901, 1100);
          default: adc_v = $urandom_range(200, 900);
        endcase
        case ($urandom_range(0, 9))
          0: adc_a = $urandom;
          1, 2: adc_a = $urandom_range(801, 1023);
          default: adc_a = $urandom_range(0, 800);
        endcase
        hold = $urandom_range(4, 40);
      end
      hold--;
      clr_fault = ($urandom_range(0, 149) == 0);
      cycle();
      clr_fault = 1'b0;
      check_all("rnd", m_state, (m_state == 1) ? 1 : 0, (m_state >= 2) ? 1 : 0, m_fc, m_power);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
